// File: rtl/mcm_step_sched_pkg.sv
// mcm_pkg: shared defaults, scheduler state encoding and the step record
// used by the matrix-chain-multiplication step scheduler.
package mcm_pkg;

  localparam int unsigned MCM_N_MAT   = 8;
  localparam int unsigned MCM_IDX_W   = 3;
  localparam int unsigned MCM_MAX_OUT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BARRIER,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  typedef struct packed {
    logic [MCM_IDX_W-1:0] i;
    logic [MCM_IDX_W-1:0] k;
    logic [MCM_IDX_W-1:0] j;
    logic                 first;
    logic                 last;
  } step_t;

endpackage

// File: rtl/mcm_step_sched_if.sv
// Step-command / response channel between the MCM scheduler (master)
// and the pipelined MCM step datapath (slave).
interface mcm_step_sched_if
  import mcm_pkg::*;
#(
  parameter int unsigned IDX_W = MCM_IDX_W
);
  logic             STEP_VALID;
  logic             STEP_READY;
  logic [IDX_W-1:0] STEP_I;
  logic [IDX_W-1:0] STEP_K;
  logic [IDX_W-1:0] STEP_J;
  logic             STEP_FIRST;
  logic             STEP_LAST;
  logic             RESP_VALID;

  modport master (
    output STEP_VALID, STEP_I, STEP_K, STEP_J, STEP_FIRST, STEP_LAST,
    input  STEP_READY, RESP_VALID
  );

  modport slave (
    input  STEP_VALID, STEP_I, STEP_K, STEP_J, STEP_FIRST, STEP_LAST,
    output STEP_READY, RESP_VALID
  );
endinterface

// File: rtl/mcm_step_sched_idx_gen.sv
// mcm_idx_gen: diagonal/row/split loop counters of the MCM DP, producing
// registered (i,k,j,first,last) plus end-of-diagonal/end-of-schedule flags.
module mcm_idx_gen
  import mcm_pkg::*;
#(
  parameter int unsigned IDX_W = MCM_IDX_W,
  parameter int unsigned LEN_W = MCM_IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_advance,
  input  logic [LEN_W-1:0] i_len,
  output logic [IDX_W-1:0] o_i,
  output logic [IDX_W-1:0] o_k,
  output logic [IDX_W-1:0] o_j,
  output logic             o_first,
  output logic             o_last,
  output logic             o_diag_end,
  output logic             o_sched_end
);

  logic [IDX_W-1:0] r_t, r_i, r_k, r_j;
  logic             r_first, r_last;
  logic [LEN_W-1:0] r_len;
  logic [IDX_W-1:0] w_t_n, w_i_n, w_k_n, w_j_n;
  logic             w_diag_end, w_sched_end;

  assign w_diag_end  = r_last && ((LEN_W'(r_i) + LEN_W'(r_t) + LEN_W'(1)) == r_len);
  assign w_sched_end = w_diag_end && ((LEN_W'(r_t) + LEN_W'(1)) == r_len);

  // New row starts at k = old i + 1, which equals the new i (k==i -> first).
  always_comb begin
    w_t_n = r_t;
    w_i_n = r_i;
    w_k_n = r_k;
    if (i_clear) begin
      w_t_n = IDX_W'(1);
      w_i_n = '0;
      w_k_n = '0;
    end else if (i_advance) begin
      if (!r_last) begin
        w_k_n = r_k + IDX_W'(1);
      end else if (!w_diag_end) begin
        w_i_n = r_i + IDX_W'(1);
        w_k_n = r_i + IDX_W'(1);
      end else if (!w_sched_end) begin
        w_t_n = r_t + IDX_W'(1);
        w_i_n = '0;
        w_k_n = '0;
      end
    end
    w_j_n = w_i_n + w_t_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len   <= '0;
      r_t     <= '0;
      r_i     <= '0;
      r_k     <= '0;
      r_j     <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (i_clear) r_len <= i_len;
      if (i_clear || i_advance) begin
        r_t     <= w_t_n;
        r_i     <= w_i_n;
        r_k     <= w_k_n;
        r_j     <= w_j_n;
        r_first <= (w_k_n == w_i_n);
        r_last  <= ((w_k_n + IDX_W'(1)) == w_j_n);
      end
    end
  end

  assign o_i         = r_i;
  assign o_k         = r_k;
  assign o_j         = r_j;
  assign o_first     = r_first;
  assign o_last      = r_last;
  assign o_diag_end  = w_diag_end;
  assign o_sched_end = w_sched_end;

endmodule

// File: rtl/mcm_step_sched.sv
// mcm_step_sched: issues MCM DP step commands in diagonal order with an
// outstanding-step throttle and a commit barrier between diagonals.
// Optional MCM_SCHED_PERF_EN adds the STALL_CNT performance counter.
module mcm_step_sched
  import mcm_pkg::*;
#(
  parameter int unsigned N_MAT   = MCM_N_MAT,
  parameter int unsigned IDX_W   = MCM_IDX_W,
  parameter int unsigned MAX_OUT = MCM_MAX_OUT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [3:0]  LEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
`ifdef MCM_SCHED_PERF_EN
  output logic [15:0] STALL_CNT,
`endif
  mcm_step_sched_if.master step
);

  localparam int unsigned LEN_W = IDX_W + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  state_t           r_state, w_state_n;
  logic [OUT_W-1:0] r_out, w_out_n;
  logic             r_busy, r_done, r_err;
  logic [LEN_W-1:0] w_len_c;
  logic             w_short, w_valid, w_accept, w_start_acc, w_clear;
  logic             w_resp_eff, w_err_set;
  logic [IDX_W-1:0] w_i, w_k, w_j;
  logic             w_first, w_last, w_diag_end, w_sched_end;

  assign w_len_c = (32'(LEN) > N_MAT) ? LEN_W'(N_MAT) : LEN_W'(LEN);
  assign w_short = (w_len_c < LEN_W'(2));

  mcm_idx_gen #(
    .IDX_W (IDX_W),
    .LEN_W (LEN_W)
  ) u_idx_gen (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .i_clear     (w_clear),
    .i_advance   (w_accept),
    .i_len       (w_len_c),
    .o_i         (w_i),
    .o_k         (w_k),
    .o_j         (w_j),
    .o_first     (w_first),
    .o_last      (w_last),
    .o_diag_end  (w_diag_end),
    .o_sched_end (w_sched_end)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:    if (START) w_state_n = w_short ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:   if (w_accept && w_diag_end) w_state_n = w_sched_end ? ST_DRAIN : ST_BARRIER;
      ST_BARRIER: if (w_out_n == '0) w_state_n = ST_ISSUE;
      ST_DRAIN:   if (w_out_n == '0) w_state_n = ST_FINISH;
      ST_FINISH:  w_state_n = ST_IDLE;
      default:    w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid     = (r_state == ST_ISSUE) && (r_out < OUT_W'(MAX_OUT));
    w_accept    = w_valid && step.STEP_READY;
    w_start_acc = (r_state == ST_IDLE) && START;
    w_clear     = w_start_acc && !w_short;
  end

  // A response with nothing outstanding is only legal if it pairs with a same-cycle accept.
  always_comb begin
    w_resp_eff = step.RESP_VALID && ((r_out != '0) || w_accept);
    w_out_n    = r_out + OUT_W'(w_accept) - OUT_W'(w_resp_eff);
    w_err_set  = (step.RESP_VALID && !w_resp_eff) || (START && r_busy);
  end

  // DONE is registered off FINISH, so it lands in the cycle BUSY falls.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_out  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_out  <= w_out_n;
      r_done <= (r_state == ST_FINISH);
      if (w_start_acc)               r_busy <= 1'b1;
      else if (r_state == ST_FINISH) r_busy <= 1'b0;
      r_err  <= (w_start_acc ? 1'b0 : r_err) | w_err_set;
    end
  end

`ifdef MCM_SCHED_PERF_EN
  logic [15:0] r_stall;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall <= '0;
    end else if (w_start_acc) begin
      r_stall <= '0;
    end else if (r_busy && !w_accept && (r_stall != '1)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign STALL_CNT = r_stall;
`endif

  assign BUSY            = r_busy;
  assign DONE            = r_done;
  assign ERR             = r_err;
  assign step.STEP_VALID = w_valid;
  assign step.STEP_I     = w_i;
  assign step.STEP_K     = w_k;
  assign step.STEP_J     = w_j;
  assign step.STEP_FIRST = w_first;
  assign step.STEP_LAST  = w_last;

endmodule

// File: tb/tb_mcm_step_sched.sv
// Directed bench for mcm_step_sched: step order, throttle, barrier,
// backpressure hold, degenerate lengths, error flag and mid-run reset.
module tb_mcm_step_sched;
  import mcm_pkg::*;

  localparam int unsigned IDX_W   = MCM_IDX_W;
  localparam int unsigned MAX_OUT = MCM_MAX_OUT;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [3:0]  LEN;
  logic        BUSY, DONE, ERR;
`ifdef MCM_SCHED_PERF_EN
  logic [15:0] STALL_CNT;
`endif
  logic        resp_auto = 1'b0;
  logic        spur;
  int unsigned resp_dly = 1;

  int n_cmp = 0;
  int n_err = 0;

  mcm_step_sched_if #(.IDX_W(IDX_W)) sif ();
  assign sif.RESP_VALID = resp_auto | spur;

  mcm_step_sched #(
    .N_MAT   (MCM_N_MAT),
    .IDX_W   (IDX_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .LEN       (LEN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR),
`ifdef MCM_SCHED_PERF_EN
    .STALL_CNT (STALL_CNT),
`endif
    .step      (sif)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Datapath model and protocol monitor, sampling mid-cycle.
  logic [IDX_W-1:0] prev_t, t_cur;
  logic [IDX_W-1:0] hold_i, hold_k, hold_j;
  logic             hold_f, hold_l;
  logic             stalled;
  logic [63:0]      pipe;
  int unsigned      tb_out = 0, max_out = 0;
  int unsigned      acc_cnt = 0, acc_run = 0, resp_run = 0;
  int unsigned      done_cnt = 0, valid_cnt = 0;
  step_t            acc_log[$];

  always @(negedge CLK) begin
    bit acc, resp;
    if (!RESET_N) begin
      pipe      = '0;
      resp_auto = 1'b0;
      tb_out    = 0;
      stalled   = 1'b0;
      prev_t    = '0;
      acc_run   = 0;
      resp_run  = 0;
    end else begin
      if (START && !BUSY) begin
        acc_run  = 0;
        resp_run = 0;
        prev_t   = '0;
        max_out  = 0;
      end
      pipe      = pipe >> 1;
      resp_auto = pipe[0];
      acc  = sif.STEP_VALID && sif.STEP_READY;
      resp = (resp_auto | spur) && ((tb_out != 0) || acc);
      if (stalled) begin
        chk("hold_valid", sif.STEP_VALID, 1);
        chk("hold_idx", {sif.STEP_I, sif.STEP_K, sif.STEP_J, sif.STEP_FIRST, sif.STEP_LAST},
            {hold_i, hold_k, hold_j, hold_f, hold_l});
      end
      if (acc) begin
        t_cur = sif.STEP_J - sif.STEP_I;
        if (t_cur != prev_t) begin
          chk("barrier", resp_run >= acc_run, 1);
          prev_t = t_cur;
        end
        acc_log.push_back('{i: sif.STEP_I, k: sif.STEP_K, j: sif.STEP_J,
                            first: sif.STEP_FIRST, last: sif.STEP_LAST});
        acc_cnt++;
        acc_run++;
        pipe[resp_dly] = 1'b1;
      end
      if (resp) resp_run++;
      tb_out = tb_out + 32'(acc) - 32'(resp);
      if (tb_out > max_out) max_out = tb_out;
      if (acc) chk("throttle", tb_out <= MAX_OUT, 1);
      stalled = sif.STEP_VALID && !sif.STEP_READY;
      hold_i  = sif.STEP_I;
      hold_k  = sif.STEP_K;
      hold_j  = sif.STEP_J;
      hold_f  = sif.STEP_FIRST;
      hold_l  = sif.STEP_LAST;
      if (DONE)           done_cnt++;
      if (sif.STEP_VALID) valid_cnt++;
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_run(input logic [3:0] len);
    START = 1'b1;
    LEN   = len;
    cyc(1);
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned c = 0;
    while (DONE !== 1'b1 && c < budget) begin
      cyc(1);
      c++;
    end
    chk(tag, DONE, 1);
  endtask

  initial begin
    step_t       exp3[4];
    int unsigned base, a0, d0, v0, c;

    exp3[0] = '{i: 3'd0, k: 3'd0, j: 3'd1, first: 1'b1, last: 1'b1};
    exp3[1] = '{i: 3'd1, k: 3'd1, j: 3'd2, first: 1'b1, last: 1'b1};
    exp3[2] = '{i: 3'd0, k: 3'd0, j: 3'd2, first: 1'b1, last: 1'b0};
    exp3[3] = '{i: 3'd0, k: 3'd1, j: 3'd2, first: 1'b0, last: 1'b1};

    RESET_N = 1'b0;
    START = 1'b0;
    LEN = 4'd0;
    spur = 1'b0;
    sif.STEP_READY = 1'b1;
    cyc(2);
    chk("reset_state", {BUSY, DONE, ERR, sif.STEP_VALID, sif.STEP_I, sif.STEP_K, sif.STEP_J,
                        sif.STEP_FIRST, sif.STEP_LAST}, 0);
    RESET_N = 1'b1;
    cyc(2);

    // LEN=3 trace order
    base = acc_log.size(); a0 = acc_cnt; d0 = done_cnt;
    start_run(4'd3);
    chk("t3_busy", BUSY, 1);
    wait_done("t3_done", 100);
    chk("t3_resp_at_done", resp_run, 4);
    chk("t3_busy_at_done", BUSY, 0);
    cyc(1);
    chk("t3_done_pulse", DONE, 0);
    chk("t3_accepts", acc_cnt - a0, 4);
    chk("t3_done_cnt", done_cnt - d0, 1);
    for (int n = 0; n < 4; n++) chk($sformatf("t3_step%0d", n), acc_log[base + n], exp3[n]);

    // LEN=8, responses delayed 6 cycles
    resp_dly = 6;
    a0 = acc_cnt; d0 = done_cnt;
    start_run(4'd8);
    wait_done("full_done", 3000);
    cyc(1);
    chk("full_accepts", acc_cnt - a0, 84);
    chk("full_max_out", max_out, MAX_OUT);
    chk("full_done_cnt", done_cnt - d0, 1);
    chk("full_err", ERR, 0);

    // LEN=4 with random backpressure
    resp_dly = 1;
    a0 = acc_cnt; d0 = done_cnt;
    start_run(4'd4);
    c = 0;
    while (DONE !== 1'b1 && c < 1000) begin
      sif.STEP_READY = 1'($urandom_range(0, 1));
      cyc(1);
      c++;
    end
    sif.STEP_READY = 1'b1;
    chk("bp_done", DONE, 1);
    cyc(1);
    chk("bp_accepts", acc_cnt - a0, 10);
    chk("bp_done_cnt", done_cnt - d0, 1);

    // LEN=1: no steps, DONE on the second cycle after START
    a0 = acc_cnt; v0 = valid_cnt;
    start_run(4'd1);
    chk("l1_busy", BUSY, 1);
    chk("l1_done_early", DONE, 0);
    cyc(1);
    chk("l1_done", DONE, 1);
    chk("l1_busy_off", BUSY, 0);
    cyc(1);
    chk("l1_done_off", DONE, 0);
    chk("l1_valid_cycles", valid_cnt - v0, 0);
    chk("l1_accepts", acc_cnt - a0, 0);
`ifdef MCM_SCHED_PERF_EN
    chk("l1_stall_cnt", STALL_CNT, 1);
`endif

    // LEN=12 clamps to 8
    a0 = acc_cnt;
    start_run(4'd12);
    wait_done("clamp_done", 3000);
    cyc(1);
    chk("clamp_accepts", acc_cnt - a0, 84);

    // START while BUSY
    a0 = acc_cnt;
    start_run(4'd3);
    cyc(2);
    chk("err_before", ERR, 0);
    START = 1'b1;
    LEN = 4'd2;
    cyc(1);
    START = 1'b0;
    chk("err_start_busy", ERR, 1);
    wait_done("err_done", 100);
    cyc(1);
    chk("err_accepts", acc_cnt - a0, 4);
    chk("err_sticky", ERR, 1);
    start_run(4'd1);
    chk("err_clear", ERR, 0);
    cyc(3);
    spur = 1'b1;
    cyc(1);
    spur = 1'b0;
    chk("err_spur_resp", ERR, 1);
    start_run(4'd1);
    chk("err_clear2", ERR, 0);
    cyc(3);

    // Reset mid-schedule, then LEN=2
    start_run(4'd8);
    cyc(2);
    chk("rst_in_issue", sif.STEP_VALID, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_async", {BUSY, DONE, ERR, sif.STEP_VALID, sif.STEP_I, sif.STEP_K, sif.STEP_J,
                      sif.STEP_FIRST, sif.STEP_LAST}, 0);
    cyc(2);
    RESET_N = 1'b1;
    cyc(1);
    a0 = acc_cnt; d0 = done_cnt;
    start_run(4'd2);
    wait_done("l2_done", 100);
    cyc(1);
    chk("l2_accepts", acc_cnt - a0, 1);
    chk("l2_done_cnt", done_cnt - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mcm_step_sched.md
Name: mcm_step_sched

Overview:
- Sequencer for the matrix-chain-multiplication DP datapath.
- Walks the DP loop order (diagonal t, row i, split k) and issues one step command per (i,k,j) triple over a valid/ready handshake.
- Counts datapath commit acknowledgements and enforces a barrier between diagonals, so no cell is computed before the cells it depends on are committed.
- Sits between the input-capture logic, which supplies LEN and START, and a pipelined MCM step datapath.

Parameters:
- N_MAT, 8, maximum number of matrices in a chain (DP index range 0..N_MAT-1).
- IDX_W, 3, width of the i/k/j index fields; must satisfy 2^IDX_W >= N_MAT.
- MAX_OUT, 4, maximum number of steps issued but not yet acknowledged.

Ports:
- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle pulse that begins a schedule; honoured only in IDLE
- LEN  in  4  number of matrices; sampled on the accepted START
- BUSY  out  1  high from the cycle after an accepted START until DONE
- STEP_VALID  out  1  step command valid
- STEP_READY  in  1  datapath accepts the step
- STEP_I  out  IDX_W  row index i
- STEP_K  out  IDX_W  split index k
- STEP_J  out  IDX_W  column index j = i+t
- STEP_FIRST  out  1  k==i; datapath initialises min[i][j]
- STEP_LAST  out  1  k==j-1; datapath commits min[i][j]
- RESP_VALID  in  1  datapath finished one step (one pulse per accepted step)
- DONE  out  1  one-cycle pulse when every step has been acknowledged
- ERR  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, RESET_N=0) values:
  - state=IDLE
  - BUSY=0, STEP_VALID=0, DONE=0, ERR=0
  - STEP_I, STEP_K and STEP_J=0; STEP_FIRST=0; STEP_LAST=0
  - outstanding count=0
- LEN handling on an accepted START:
  - LEN is clamped to N_MAT when it exceeds N_MAT.
  - LEN<2 goes IDLE->FINISH: DONE pulses on the second cycle after START and no steps are issued.
- State machine:
  - IDLE: on START, latch the clamped LEN, set t=1, i=0, k=0, go to ISSUE.
  - ISSUE: STEP_VALID=1 when outstanding<MAX_OUT, else 0. A step is accepted when STEP_VALID&&STEP_READY; on acceptance the indices advance.
    - If k!=j-1: k++.
    - Else if i!=LEN-1-t: i++, k=i+1.
    - Else, if t==LEN-1, go to DRAIN; otherwise go to BARRIER with t++, i=0, k=0.
  - BARRIER: STEP_VALID=0; when outstanding==0 (including the same-cycle decrement), go to ISSUE.
  - DRAIN: STEP_VALID=0; when outstanding==0, go to FINISH.
  - FINISH: DONE=1 for one cycle, BUSY drops in the same cycle, go to IDLE.
- Index outputs:
  - Indices are registered and stable while STEP_VALID=1 and STEP_READY=0.
  - STEP_VALID is never withdrawn without acceptance except by reset.
- Outstanding counter:
  - Increments on accept and decrements on RESP_VALID; both in the same cycle leave it unchanged.
  - Width is clog2(MAX_OUT+1).
- Total accepted steps equal the sum over t=1..LEN-1 of (LEN-t)*t. LEN=8 gives 84; LEN=3 gives 4; LEN=2 gives 1.
- ERR is set by either:
  - RESP_VALID while outstanding==0 and no same-cycle accept (the response is ignored, counter stays 0);
  - START while BUSY (START is ignored, schedule continues).
- ERR clears only on reset or on an accepted START from IDLE.
- Asserting RESET_N low mid-schedule aborts immediately; datapath state is not touched.

Optional Feature:
- MCM_SCHED_PERF_EN:
  - Defined: adds output STALL_CNT[15:0]. It clears on accepted START and increments each cycle BUSY=1 with no step accepted (BARRIER, DRAIN, backpressure, MAX_OUT throttle). It saturates at 16'hFFFF and holds after DONE.
  - Undefined: no port and no counter logic.

Decomposition:
- Package mcm_pkg holds:
  - N_MAT, IDX_W, MAX_OUT defaults;
  - the state enum (IDLE, ISSUE, BARRIER, DRAIN, FINISH);
  - a step_t struct {i,k,j,first,last}.
- Sub-module mcm_idx_gen: the t/i/k loop counters, with inputs advance/clear/len and outputs i,k,j,first,last,diag_end,sched_end. The FSM and outstanding counter stay in mcm_step_sched.

Test Plan:
- Trace order: LEN=3, STEP_READY=1, RESP_VALID one cycle after each accept. Required accept sequence, as (i,k,j): (0,0,1)F/L, (1,1,2)F/L, then barrier, then (0,0,2)F, (0,1,2)L. DONE comes after the 4th response; 4 accepts total.
- Full chain with throttle: LEN=8, STEP_READY=1, responses delayed 6 cycles. Required: 84 accepts, outstanding never >4, no t=2 step accepted before all 7 t=1 responses, DONE once.
- Backpressure: LEN=4, STEP_READY toggled randomly. Required: indices stable whenever STEP_VALID&&!STEP_READY, 10 accepts, DONE.
- Degenerate lengths: LEN=1 gives DONE 2 cycles after START with zero STEP_VALID. LEN=12 is clamped and gives 84 accepts.
- Errors: START while BUSY sets ERR and the schedule is unaffected. A spurious RESP_VALID in IDLE sets ERR. A subsequent accepted START clears ERR.
- Reset mid-run: RESET_N low during ISSUE at LEN=8. All outputs return to reset values asynchronously, and the next START with LEN=2 gives 1 accept and DONE.
